// File: rtl/alucomp_pkg.sv
// Shared definitions for the compare pipeline: op encodings and comparison helpers.
package alucomp_pkg;

   typedef enum logic [2:0] {
      OP_EQ  = 3'd0,
      OP_NE  = 3'd1,
      OP_LT  = 3'd2,
      OP_GE  = 3'd3,
      OP_LTU = 3'd4,
      OP_GEU = 3'd5
   } cmp_op_e;

   localparam logic [2:0] OP_LAST_LEGAL = 3'd5;

   // Encodings 6 and 7 have no compare meaning.
   function automatic logic is_illegal_op(input logic [2:0] op);
      return op > OP_LAST_LEGAL;
   endfunction

   // Turns the subtraction flags of a-b into the requested compare bit.
   // Illegal encodings yield 0.
   function automatic logic eval_cmp(input logic [2:0] op,
                                     input logic       sign,
                                     input logic       zero,
                                     input logic       ovf,
                                     input logic       borrow);
      logic lt;
      lt = sign ^ ovf;
      case (op)
         OP_EQ:   return zero;
         OP_NE:   return ~zero;
         OP_LT:   return lt;
         OP_GE:   return ~lt;
         OP_LTU:  return borrow;
         OP_GEU:  return ~borrow;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alucomp_pipe_if.sv
// Operand/result handshake bundle for alucomp_pipe.
// master = producer/consumer side, slave = the pipeline itself.
interface alucomp_pipe_if #(
   parameter int WIDTH = 32,
   parameter int TAGW  = 4
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic [TAGW-1:0]  in_tag;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [TAGW-1:0]  out_tag;
   logic             op_err;

   modport master (
      output in_valid, a, b, op, in_tag, out_ready,
      input  in_ready, out_valid, result, out_tag, op_err
   );

   modport slave (
      input  in_valid, a, b, op, in_tag, out_ready,
      output in_ready, out_valid, result, out_tag, op_err
   );

endinterface

// File: rtl/aluaddsub_w.sv
// WIDTH-bit adder/subtractor computed at WIDTH+1 bits, exposing the flags
// needed for signed and unsigned comparison.
module aluaddsub_w #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             sign,
   output logic             zero,
   output logic             overflow,
   output logic             borrow
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   full;
   logic [WIDTH-1:0] sum;

   // Two's-complement add of a and (optionally inverted) b; for subtraction the
   // carry-out is the inverse of the unsigned borrow.
   always_comb begin
      b_eff    = sub ? ~b : b;
      full     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
      sum      = full[WIDTH-1:0];
      sign     = sum[WIDTH-1];
      zero     = (sum == '0);
      overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      borrow   = sub ? ~full[WIDTH] : full[WIDTH];
   end

endmodule

// File: rtl/alucomp_pipe.sv
// Two-stage valid/ready compare pipeline. S1 captures subtraction flags of
// a-b, S2 turns them into a single compare bit plus an illegal-op flag.
module alucomp_pipe
   import alucomp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAGW  = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   alucomp_pipe_if.slave  bus
);

   logic sub_sign, sub_zero, sub_ovf, sub_borrow;

   logic            s1_valid_q, s1_valid_d;
   logic            s1_sign_q, s1_sign_d;
   logic            s1_zero_q, s1_zero_d;
   logic            s1_ovf_q, s1_ovf_d;
   logic            s1_borrow_q, s1_borrow_d;
   logic [2:0]      s1_op_q, s1_op_d;
   logic [TAGW-1:0] s1_tag_q, s1_tag_d;

   logic            s2_valid_q, s2_valid_d;
   logic            cmp_q, cmp_d;
   logic [TAGW-1:0] out_tag_q, out_tag_d;
   logic            op_err_q, op_err_d;

   logic s1_ready, s2_ready;

   aluaddsub_w #(.WIDTH(WIDTH)) u_addsub (
      .a        (bus.a),
      .b        (bus.b),
      .sub      (1'b1),
      .sign     (sub_sign),
      .zero     (sub_zero),
      .overflow (sub_ovf),
      .borrow   (sub_borrow)
   );

   assign s2_ready      = ~s2_valid_q | bus.out_ready;
   assign s1_ready      = ~s1_valid_q | s2_ready;
   assign bus.in_ready  = s1_ready;
   assign bus.out_valid = s2_valid_q;
   assign bus.result    = {{(WIDTH-1){1'b0}}, cmp_q};
   assign bus.out_tag   = out_tag_q;
   assign bus.op_err    = op_err_q;

   // Next-state for both stages: a stage loads only when it is free or being
   // drained this cycle; payload registers otherwise keep their last value.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_sign_d   = s1_sign_q;
      s1_zero_d   = s1_zero_q;
      s1_ovf_d    = s1_ovf_q;
      s1_borrow_d = s1_borrow_q;
      s1_op_d     = s1_op_q;
      s1_tag_d    = s1_tag_q;
      s2_valid_d  = s2_valid_q;
      cmp_d       = cmp_q;
      out_tag_d   = out_tag_q;
      op_err_d    = op_err_q;

      if (s1_ready) begin
         s1_valid_d = bus.in_valid;
         if (bus.in_valid) begin
            s1_sign_d   = sub_sign;
            s1_zero_d   = sub_zero;
            s1_ovf_d    = sub_ovf;
            s1_borrow_d = sub_borrow;
            s1_op_d     = bus.op;
            s1_tag_d    = bus.in_tag;
         end
      end

      if (s2_ready) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            cmp_d     = eval_cmp(s1_op_q, s1_sign_q, s1_zero_q, s1_ovf_q, s1_borrow_q);
            out_tag_d = s1_tag_q;
            op_err_d  = is_illegal_op(s1_op_q);
         end
      end
   end

   // Pipeline registers; reset empties both stages and zeroes visible outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_sign_q   <= 1'b0;
         s1_zero_q   <= 1'b0;
         s1_ovf_q    <= 1'b0;
         s1_borrow_q <= 1'b0;
         s1_op_q     <= 3'd0;
         s1_tag_q    <= '0;
         s2_valid_q  <= 1'b0;
         cmp_q       <= 1'b0;
         out_tag_q   <= '0;
         op_err_q    <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_sign_q   <= s1_sign_d;
         s1_zero_q   <= s1_zero_d;
         s1_ovf_q    <= s1_ovf_d;
         s1_borrow_q <= s1_borrow_d;
         s1_op_q     <= s1_op_d;
         s1_tag_q    <= s1_tag_d;
         s2_valid_q  <= s2_valid_d;
         cmp_q       <= cmp_d;
         out_tag_q   <= out_tag_d;
         op_err_q    <= op_err_d;
      end
   end

endmodule

// File: tb/tb_alucomp_pipe.sv
// Directed self-checking bench for alucomp_pipe (WIDTH=32 and WIDTH=8 instances).
module tb_alucomp_pipe;
   import alucomp_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   alucomp_pipe_if #(.WIDTH(32), .TAGW(4)) bus32 ();
   alucomp_pipe_if #(.WIDTH(8),  .TAGW(4)) bus8 ();

   alucomp_pipe #(.WIDTH(32), .TAGW(4)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus32.slave)
   );

   alucomp_pipe #(.WIDTH(8), .TAGW(4)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus8.slave)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one transaction into the 32-bit DUT and waits (bounded) for it to
   // emerge; got=0 means it never appeared.
   task automatic run_single(input logic [31:0] a, input logic [31:0] b,
                             input logic [2:0] op, input logic [3:0] tag,
                             output logic [31:0] res, output logic [3:0] tg,
                             output logic err, output bit got);
      bus32.a         = a;
      bus32.b         = b;
      bus32.op        = op;
      bus32.in_tag    = tag;
      bus32.in_valid  = 1'b1;
      bus32.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (bus32.in_ready) begin
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      bus32.in_valid = 1'b0;
      got = 0;
      res = '0;
      tg  = '0;
      err = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus32.out_valid) begin
            got = 1;
            res = bus32.result;
            tg  = bus32.out_tag;
            err = bus32.op_err;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   // Same as run_single, for the 8-bit instance.
   task automatic run_single8(input logic [7:0] a, input logic [7:0] b,
                              input logic [2:0] op, input logic [3:0] tag,
                              output logic [7:0] res, output logic err,
                              output bit got);
      bus8.a         = a;
      bus8.b         = b;
      bus8.op        = op;
      bus8.in_tag    = tag;
      bus8.in_valid  = 1'b1;
      bus8.out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (bus8.in_ready) begin
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
      end
      bus8.in_valid = 1'b0;
      got = 0;
      res = '0;
      err = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus8.out_valid) begin
            got = 1;
            res = bus8.result;
            err = bus8.op_err;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
      bus32.a = '0; bus32.b = '0; bus32.op = 3'd0; bus32.in_tag = '0;
      bus8.in_valid = 1'b0; bus8.out_ready = 1'b1;
      bus8.a = '0; bus8.b = '0; bus8.op = 3'd0; bus8.in_tag = '0;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (bus32.out_valid !== 1'b0 || bus32.result !== 32'd0 ||
          bus32.out_tag !== 4'd0 || bus32.op_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got v=%b r=%h t=%h e=%b want 0/0/0/0",
                  bus32.out_valid, bus32.result, bus32.out_tag, bus32.op_err);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus32.in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_in_ready: got %b want 1", bus32.in_ready);
      end
   endtask

   task automatic test_signed_lt();
      logic [31:0] res; logic [3:0] tg; logic err; bit got;
      run_single(32'hFFFF_FFFF, 32'd1, OP_LT, 4'd1, res, tg, err, got);
      checks++;
      if (!got || res !== 32'd1 || err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL lt_neg1_vs_1: got(seen=%0d) r=%h e=%b want r=1 e=0", got, res, err);
      end
      run_single(32'hFFFF_FFFF, 32'd1, OP_LTU, 4'd2, res, tg, err, got);
      checks++;
      if (!got || res !== 32'd0 || err !== 1'b0 || tg !== 4'd2) begin
         failures++;
         $display("[TB] FAIL ltu_max_vs_1: got(seen=%0d) r=%h e=%b t=%h want r=0 e=0 t=2",
                  got, res, err, tg);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] res; logic [3:0] tg; logic err; bit got;
      run_single(32'h7FFF_FFFF, 32'h8000_0000, OP_LT, 4'd3, res, tg, err, got);
      checks++;
      if (!got || res !== 32'd0) begin
         failures++;
         $display("[TB] FAIL lt_overflow: got(seen=%0d) r=%h want 0", got, res);
      end
      run_single(32'h7FFF_FFFF, 32'h8000_0000, OP_GE, 4'd4, res, tg, err, got);
      checks++;
      if (!got || res !== 32'd1) begin
         failures++;
         $display("[TB] FAIL ge_overflow: got(seen=%0d) r=%h want 1", got, res);
      end
   endtask

   task automatic test_eq_ne_unsigned();
      logic [31:0] res; logic [3:0] tg; logic err; bit got;
      run_single(32'd5, 32'd5, OP_EQ, 4'd5, res, tg, err, got);
      checks++;
      if (!got || res !== 32'd1) begin
         failures++;
         $display("[TB] FAIL eq_equal: got(seen=%0d) r=%h want 1", got, res);
      end
      run_single(32'd5, 32'd5, OP_NE, 4'd6, res, tg, err, got);
      checks++;
      if (!got || res !== 32'd0) begin
         failures++;
         $display("[TB] FAIL ne_equal: got(seen=%0d) r=%h want 0", got, res);
      end
      run_single(32'd3, 32'd7, OP_GEU, 4'd7, res, tg, err, got);
      checks++;
      if (!got || res !== 32'd0) begin
         failures++;
         $display("[TB] FAIL geu_3_7: got(seen=%0d) r=%h want 0", got, res);
      end
      run_single(32'h8000_0000, 32'd3, OP_GEU, 4'd8, res, tg, err, got);
      checks++;
      if (!got || res !== 32'd1) begin
         failures++;
         $display("[TB] FAIL geu_big_3: got(seen=%0d) r=%h want 1", got, res);
      end
      run_single(32'h8000_0000, 32'd3, OP_GE, 4'd9, res, tg, err, got);
      checks++;
      if (!got || res !== 32'd0) begin
         failures++;
         $display("[TB] FAIL ge_negative_3: got(seen=%0d) r=%h want 0", got, res);
      end
   endtask

   task automatic test_illegal_op();
      logic [31:0] res; logic [3:0] tg; logic err; bit got;
      run_single(32'd5, 32'd5, 3'd6, 4'd9, res, tg, err, got);
      checks++;
      if (!got || res !== 32'd0 || err !== 1'b1 || tg !== 4'd9) begin
         failures++;
         $display("[TB] FAIL illegal_op6: got(seen=%0d) r=%h e=%b t=%h want r=0 e=1 t=9",
                  got, res, err, tg);
      end
      run_single(32'd5, 32'd5, OP_EQ, 4'd10, res, tg, err, got);
      checks++;
      if (!got || res !== 32'd1 || err !== 1'b0 || tg !== 4'd10) begin
         failures++;
         $display("[TB] FAIL legal_after_illegal: got(seen=%0d) r=%h e=%b t=%h want r=1 e=0 t=a",
                  got, res, err, tg);
      end
      run_single(32'd1, 32'd2, 3'd7, 4'd11, res, tg, err, got);
      checks++;
      if (!got || res !== 32'd0 || err !== 1'b1) begin
         failures++;
         $display("[TB] FAIL illegal_op7: got(seen=%0d) r=%h e=%b want r=0 e=1", got, res, err);
      end
   endtask

   // Tags 0..7 presented on consecutive cycles (first presentation cycle = cycle 1).
   // Each is LTU(tag, 3), so the expected bit is 1 for tags 0..2.
   task automatic test_back_to_back();
      int seen;
      int bad;
      seen = 0;
      bad  = 0;
      bus32.out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (k >= 2 && k <= 9) begin
            if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 4'(k - 2) ||
                bus32.result !== ((k - 2) < 3 ? 32'd1 : 32'd0)) begin
               bad++;
               $display("[TB] FAIL b2b_slot%0d: got v=%b t=%h r=%h want v=1 t=%0d",
                        k, bus32.out_valid, bus32.out_tag, bus32.result, k - 2);
            end else begin
               seen++;
            end
         end else if (bus32.out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_idle%0d: got out_valid=%b want 0", k, bus32.out_valid);
         end
         if (k < 8) begin
            if (bus32.in_ready !== 1'b1) begin
               bad++;
               $display("[TB] FAIL b2b_in_ready%0d: got %b want 1", k, bus32.in_ready);
            end
            bus32.in_valid = 1'b1;
            bus32.a        = 32'(k);
            bus32.b        = 32'd3;
            bus32.op       = OP_LTU;
            bus32.in_tag   = 4'(k);
         end else begin
            bus32.in_valid = 1'b0;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (bad != 0 || seen != 8) begin
         failures++;
         $display("[TB] FAIL back_to_back: got %0d in-order results with %0d errors want 8 and 0",
                  seen, bad);
      end
   endtask

   // Stream tags 0..5 of GE(tag, 2) with out_ready low for the first 7 cycles.
   task automatic test_backpressure();
      int tx, rx, bad;
      logic [31:0] held_res;
      logic [3:0]  held_tag;
      logic        held_err;
      tx = 0; rx = 0; bad = 0;
      held_res = '0; held_tag = '0; held_err = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         bus32.out_ready = (cyc >= 7);
         bus32.in_valid  = (tx < 6);
         bus32.a         = 32'(tx);
         bus32.b         = 32'd2;
         bus32.op        = OP_GE;
         bus32.in_tag    = 4'(tx);
         #1;
         if (cyc == 2) begin
            held_res = bus32.result;
            held_tag = bus32.out_tag;
            held_err = bus32.op_err;
         end
         if (cyc >= 3 && cyc <= 6 &&
             (bus32.out_valid !== 1'b1 || bus32.result !== held_res ||
              bus32.out_tag !== held_tag || bus32.op_err !== held_err)) begin
            bad++;
            $display("[TB] FAIL bp_hold%0d: got v=%b r=%h t=%h want v=1 r=%h t=%h",
                     cyc, bus32.out_valid, bus32.result, bus32.out_tag, held_res, held_tag);
         end
         if (cyc == 6) begin
            checks++;
            if (tx != 2 || bus32.in_ready !== 1'b0 || bus32.out_tag !== 4'd0 ||
                bus32.result !== 32'd0) begin
               failures++;
               $display("[TB] FAIL bp_stall_state: got accepts=%0d in_ready=%b t=%h r=%h want 2/0/0/0",
                        tx, bus32.in_ready, bus32.out_tag, bus32.result);
            end
         end
         if (bus32.out_valid && bus32.out_ready) begin
            if (bus32.out_tag !== 4'(rx) || bus32.result !== (rx >= 2 ? 32'd1 : 32'd0)) begin
               bad++;
               $display("[TB] FAIL bp_order: got t=%h r=%h want t=%0d", bus32.out_tag,
                        bus32.result, rx);
            end
            rx++;
         end
         if (bus32.in_valid && bus32.in_ready) tx++;
         @(posedge clk); #1;
         if (rx == 6) break;
      end
      bus32.in_valid = 1'b0;
      checks++;
      if (bad != 0 || rx != 6) begin
         failures++;
         $display("[TB] FAIL backpressure: got %0d results with %0d errors want 6 and 0", rx, bad);
      end
      @(posedge clk); #1;
      checks++;
      if (bus32.out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL bp_no_duplicate: got out_valid=%b want 0", bus32.out_valid);
      end
   endtask

   task automatic test_reset_mid_flight();
      logic [31:0] res; logic [3:0] tg; logic err; bit got;
      int stray;
      bus32.out_ready = 1'b0;
      bus32.in_valid  = 1'b1;
      bus32.a = 32'd1; bus32.b = 32'd1; bus32.op = OP_EQ; bus32.in_tag = 4'd12;
      repeat (3) begin
         @(posedge clk); #1;
      end
      checks++;
      if (bus32.out_valid !== 1'b1 || bus32.in_ready !== 1'b0) begin
         failures++;
         $display("[TB] FAIL rst_prefill: got v=%b in_ready=%b want 1/0",
                  bus32.out_valid, bus32.in_ready);
      end
      #4 rst_n = 1'b0;
      #1;
      checks++;
      if (bus32.out_valid !== 1'b0 || bus32.result !== 32'd0 ||
          bus32.out_tag !== 4'd0 || bus32.op_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL rst_async_clear: got v=%b r=%h t=%h e=%b want 0/0/0/0",
                  bus32.out_valid, bus32.result, bus32.out_tag, bus32.op_err);
      end
      bus32.in_valid  = 1'b0;
      bus32.out_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      stray = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus32.out_valid !== 1'b0) stray++;
      end
      checks++;
      if (stray != 0) begin
         failures++;
         $display("[TB] FAIL rst_discard: got %0d cycles with out_valid want 0", stray);
      end
      run_single(32'd4, 32'd4, OP_EQ, 4'd3, res, tg, err, got);
      checks++;
      if (!got || res !== 32'd1 || tg !== 4'd3) begin
         failures++;
         $display("[TB] FAIL rst_recover: got(seen=%0d) r=%h t=%h want r=1 t=3", got, res, tg);
      end
   endtask

   task automatic test_width8();
      logic [7:0] res; logic err; bit got;
      run_single8(8'hFF, 8'h01, OP_LT, 4'd1, res, err, got);
      checks++;
      if (!got || res !== 8'h01 || err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL w8_lt: got(seen=%0d) r=%h e=%b want r=01 e=0", got, res, err);
      end
      run_single8(8'hFF, 8'h01, OP_LTU, 4'd2, res, err, got);
      checks++;
      if (!got || res !== 8'h00 || err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL w8_ltu: got(seen=%0d) r=%h e=%b want r=00 e=0", got, res, err);
      end
      run_single8(8'h7F, 8'h80, OP_LT, 4'd3, res, err, got);
      checks++;
      if (!got || res !== 8'h00) begin
         failures++;
         $display("[TB] FAIL w8_lt_overflow: got(seen=%0d) r=%h want 00", got, res);
      end
   endtask

   // Scenario sequence and summary.
   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_signed_lt();
      test_overflow();
      test_eq_ne_unsigned();
      test_illegal_op();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_flight();
      test_width8();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
